wb_interconnect: RTL
====================

// Module: wb_interconnect
// PURPOSE
//  Parametrised single-master -> NUM_SLAVES Wishbone B4 pipelined interconnect; replaces hand-wired SoC decode/mux/ack-OR.
//  Base/mask decode per slave, one outstanding transfer, per-transfer grant latch, response routing.
//  Adds bus-error responses (unmapped address, slave timeout, slave err) and captured error status for firmware.
// PARAMETERS
//  NUM_SLAVES      4                     number of slave ports (1..16)
//  ADDR_WIDTH      32                    address width
//  DATA_WIDTH      32                    data width; SEL width = DATA_WIDTH/8
//  SLV_BASE        {NUM_SLAVES{32'h0}}   packed array, slave i base address (slice i)
//  SLV_MASK        {NUM_SLAVES{32'h0}}   packed array, slave i match mask; hit = (adr & MASK) == (BASE & MASK)
//  TIMEOUT_CYCLES  255                   WAIT cycles before timeout error; 0 disables timeout
// PORTS
//  clk           in   1                clock
//  rst_n         in   1                async active-low reset
//  m_cyc_i       in   1                master cycle
//  m_stb_i       in   1                master strobe
//  m_we_i        in   1                master write enable
//  m_sel_i       in   DW/8             master byte selects
//  m_adr_i       in   AW               master address
//  m_dat_i       in   DW               master write data
//  m_dat_o       out  DW               read data to master
//  m_ack_o       out  1                ack to master
//  m_err_o       out  1                bus error to master
//  m_stall_o     out  1                stall to master
//  s_cyc_o       out  NUM_SLAVES       per-slave cycle
//  s_stb_o       out  NUM_SLAVES       per-slave strobe
//  s_we_o        out  1                broadcast write enable
//  s_sel_o       out  DW/8             broadcast byte selects
//  s_adr_o       out  AW               broadcast address
//  s_dat_o       out  DW               broadcast write data
//  s_dat_i       in   NUM_SLAVES*DW    per-slave read data (slice i)
//  s_ack_i       in   NUM_SLAVES       per-slave ack
//  s_err_i       in   NUM_SLAVES       per-slave err
//  s_stall_i     in   NUM_SLAVES       per-slave stall
//  err_cause_o   out  2                last error: 0 none, 1 unmapped, 2 timeout, 3 slave err
//  err_addr_o    out  AW               address of last errored transfer
// BEHAVIOUR
//  Reset: state IDLE, grant idx 0, timeout ctr 0, err_cause_o 0, err_addr_o 0; all s_cyc_o/s_stb_o/m_ack_o/m_err_o 0, m_stall_o 0.
//  Decode: combinational from m_adr_i; multiple hits -> lowest index wins; no hit -> unmapped.
//  IDLE: m_cyc_i&m_stb_i & hit i: s_cyc_o[i]=s_stb_o[i]=1, m_stall_o=s_stall_i[i];
//    accepted when !s_stall_i[i] -> latch idx=i, ctr=0, go WAIT. Stalled: stay IDLE, retry next cycle.
//  IDLE unmapped strobe: m_stall_o=0, no s_stb, capture m_adr_i -> go UNMAP.
//  UNMAP (1 cycle): m_err_o=1, err_cause_o<=1, err_addr_o<=captured addr; -> IDLE.
//  WAIT: m_stall_o=1, s_cyc_o[idx]=1, s_stb_o=0; s_ack_i/s_err_i/s_dat_i of idx forwarded combinationally
//    (zero added latency); ack or err -> IDLE; s_err_i also sets err_cause_o=3, err_addr_o=latched adr.
//    Responses from non-granted slaves ignored. m_dat_o = 0 outside WAIT.
//  Timeout: ctr increments each WAIT cycle without response; ctr==TIMEOUT_CYCLES-1 w/o response -> m_err_o=1 that cycle,
//    err_cause_o=2, go DRAIN. DRAIN (1 cycle): all s_cyc_o=0 (aborts slave), late acks ignored; -> IDLE.
//  Ack and err same cycle from granted slave: err wins, m_ack_o=0.
//  m_cyc_i drops in WAIT: abort -> IDLE same edge, no response forwarded, no error recorded.
//  Back-to-back: new strobe accepted in the IDLE cycle after response (max 1 xfer per 2 cycles).
//  Broadcast s_we/sel/adr/dat: IDLE -> m_* inputs; WAIT -> latched copies of the accepted transfer.
//  err_cause_o/err_addr_o hold until next error; async reset mid-transfer -> IDLE, all strobes low.
// STRUCTURE
//  wb_ic_pkg: typedef enum {IDLE, WAIT, UNMAP, DRAIN} ic_state_e; typedef enum logic [1:0] err_cause_e;
//    localparam ERR_NONE/UNMAPPED/TIMEOUT/SLAVE.
//  Sub-module wb_addr_match: parametrised base/mask priority decoder -> onehot hit, idx, any_hit.
//  Top: FSM, grant/addr/ctrl latches, timeout counter, response mux.
// TESTING
//  Read slave 1 (BASE 0x0200_0000, MASK 0xFFFF_0000) at 0x0200_0004, ack after 2 cycles, dat 0xDEADBEEF
//    -> m_ack_o 1 cycle, m_dat_o 0xDEADBEEF, s_stb_o[1] exactly 1 cycle.
//  Access 0x1000_0000 (unmapped) -> m_err_o 1 cycle after accept, err_cause_o=1, err_addr_o=0x1000_0000, no s_stb_o.
//  Slave 0 never acks, TIMEOUT_CYCLES=8 -> m_err_o in 8th WAIT cycle, err_cause_o=2; s_cyc_o[0] low next cycle;
//    late ack ignored.
//  Slave 2 stalls 3 cycles -> m_stall_o high 3 cycles, single s_stb_o pulse on acceptance, then normal ack.
//  Overlapping slaves 0/1 both hit -> slave 0 granted; slave 1 ack same cycle ignored.
//  m_cyc_i dropped in WAIT, slave acks next cycle -> no m_ack_o, err_cause_o unchanged; rst_n low mid-WAIT -> outputs 0.

Source files
------------

// File: rtl/wb_ic_pkg.sv
// Shared types for the single-master Wishbone interconnect.
package wb_ic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        UNMAP = 2'd2,
        DRAIN = 2'd3
    } ic_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_UNMAPPED = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_SLAVE    = 2'd3
    } err_cause_e;

    // Width needed to index n slaves; a single slave still gets one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_addr_match.sv
// Base/mask address decoder; the lowest-numbered matching slave wins.
module wb_addr_match
    import wb_ic_pkg::*;
#(
    parameter int                                NUM_SLAVES = 4,
    parameter int                                ADDR_WIDTH = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]  SLV_BASE   = '0,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]  SLV_MASK   = '0
) (
    input  logic [ADDR_WIDTH-1:0]               adr_i,
    output logic [NUM_SLAVES-1:0]               hit_o,
    output logic [idx_width(NUM_SLAVES)-1:0]    idx_o,
    output logic                                any_hit_o
);

    localparam int IDX_W = idx_width(NUM_SLAVES);

    // Walk from the highest index down so a lower match overrides a higher one.
    always_comb begin
        hit_o     = '0;
        idx_o     = '0;
        any_hit_o = 1'b0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((adr_i & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                (SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                hit_o     = '0;
                hit_o[i]  = 1'b1;
                idx_o     = IDX_W'(i);
                any_hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_interconnect.sv
// Single-master to NUM_SLAVES Wishbone B4 pipelined interconnect with one
// outstanding transfer, bus-error generation and captured error status.
//
//  state | meaning
//  IDLE  | no transfer in flight; decode and present the master strobe
//  WAIT  | transfer accepted by granted slave; forward its response
//  UNMAP | address hit no slave; return a bus error this cycle
//  DRAIN | granted slave timed out; drop its cycle for one clock
module wb_interconnect
    import wb_ic_pkg::*;
#(
    parameter int                                NUM_SLAVES     = 4,
    parameter int                                ADDR_WIDTH     = 32,
    parameter int                                DATA_WIDTH     = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]  SLV_BASE       = '0,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0]  SLV_MASK       = '0,
    parameter int                                TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             m_cyc_i,
    input  logic                             m_stb_i,
    input  logic                             m_we_i,
    input  logic [DATA_WIDTH/8-1:0]          m_sel_i,
    input  logic [ADDR_WIDTH-1:0]            m_adr_i,
    input  logic [DATA_WIDTH-1:0]            m_dat_i,
    output logic [DATA_WIDTH-1:0]            m_dat_o,
    output logic                             m_ack_o,
    output logic                             m_err_o,
    output logic                             m_stall_o,
    output logic [NUM_SLAVES-1:0]            s_cyc_o,
    output logic [NUM_SLAVES-1:0]            s_stb_o,
    output logic                             s_we_o,
    output logic [DATA_WIDTH/8-1:0]          s_sel_o,
    output logic [ADDR_WIDTH-1:0]            s_adr_o,
    output logic [DATA_WIDTH-1:0]            s_dat_o,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_dat_i,
    input  logic [NUM_SLAVES-1:0]            s_ack_i,
    input  logic [NUM_SLAVES-1:0]            s_err_i,
    input  logic [NUM_SLAVES-1:0]            s_stall_i,
    output logic [1:0]                       err_cause_o,
    output logic [ADDR_WIDTH-1:0]            err_addr_o
);

    localparam int IDX_W = idx_width(NUM_SLAVES);
    localparam int CTR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic             TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CTR_W-1:0] TO_LAST = CTR_W'(TIMEOUT_CYCLES - 1);

    ic_state_e               state_q, state_d;
    logic [IDX_W-1:0]        grant_q;
    logic [ADDR_WIDTH-1:0]   adr_q;
    logic                    we_q;
    logic [DATA_WIDTH/8-1:0] sel_q;
    logic [DATA_WIDTH-1:0]   dat_q;
    logic [CTR_W-1:0]        ctr_q;
    err_cause_e              err_cause_q;
    logic [ADDR_WIDTH-1:0]   err_addr_q;

    logic [NUM_SLAVES-1:0]   hit;
    logic [IDX_W-1:0]        hit_idx;
    logic                    any_hit;

    logic strobe, accept, unmap_req, in_wait, abort;
    logic g_ack, g_err, rsp_ack, rsp_err, timeout;

    wb_addr_match #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK)
    ) u_match (
        .adr_i     (m_adr_i),
        .hit_o     (hit),
        .idx_o     (hit_idx),
        .any_hit_o (any_hit)
    );

    // Transfer events; a dropped m_cyc_i in WAIT masks every response.
    always_comb begin
        strobe    = m_cyc_i & m_stb_i;
        accept    = (state_q == IDLE) & strobe & any_hit & ~s_stall_i[hit_idx];
        unmap_req = (state_q == IDLE) & strobe & ~any_hit;
        in_wait   = (state_q == WAIT);
        abort     = in_wait & ~m_cyc_i;
        g_ack     = s_ack_i[grant_q];
        g_err     = s_err_i[grant_q];
        rsp_err   = in_wait & m_cyc_i & g_err;
        rsp_ack   = in_wait & m_cyc_i & g_ack & ~g_err;
        timeout   = in_wait & m_cyc_i & ~g_ack & ~g_err & TO_EN & (ctr_q == TO_LAST);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept)         state_d = WAIT;
                else if (unmap_req) state_d = UNMAP;
            end
            WAIT: begin
                if (abort || rsp_ack || rsp_err) state_d = IDLE;
                else if (timeout)                state_d = DRAIN;
            end
            UNMAP:   state_d = IDLE;
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant/transfer latches, wait counter and firmware-visible error status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q     <= '0;
            adr_q       <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            dat_q       <= '0;
            ctr_q       <= '0;
            err_cause_q <= ERR_NONE;
            err_addr_q  <= '0;
        end else begin
            if (accept) begin
                grant_q <= hit_idx;
                adr_q   <= m_adr_i;
                we_q    <= m_we_i;
                sel_q   <= m_sel_i;
                dat_q   <= m_dat_i;
                ctr_q   <= '0;
            end else if (unmap_req) begin
                adr_q   <= m_adr_i;
            end else if (in_wait) begin
                ctr_q   <= ctr_q + 1'b1;
            end

            if (state_q == UNMAP) begin
                err_cause_q <= ERR_UNMAPPED;
                err_addr_q  <= adr_q;
            end else if (rsp_err) begin
                err_cause_q <= ERR_SLAVE;
                err_addr_q  <= adr_q;
            end else if (timeout) begin
                err_cause_q <= ERR_TIMEOUT;
                err_addr_q  <= adr_q;
            end
        end
    end

    // Output decode: strobe routing in IDLE, response forwarding in WAIT.
    always_comb begin
        s_cyc_o   = '0;
        s_stb_o   = '0;
        m_stall_o = 1'b0;
        m_ack_o   = 1'b0;
        m_err_o   = 1'b0;
        m_dat_o   = '0;
        s_we_o    = (state_q == IDLE) ? m_we_i  : we_q;
        s_sel_o   = (state_q == IDLE) ? m_sel_i : sel_q;
        s_adr_o   = (state_q == IDLE) ? m_adr_i : adr_q;
        s_dat_o   = (state_q == IDLE) ? m_dat_i : dat_q;
        unique case (state_q)
            IDLE: begin
                if (strobe && any_hit) begin
                    s_cyc_o   = hit;
                    s_stb_o   = hit;
                    m_stall_o = s_stall_i[hit_idx];
                end
            end
            WAIT: begin
                m_stall_o = 1'b1;
                m_dat_o   = s_dat_i[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
                if (m_cyc_i) s_cyc_o[grant_q] = 1'b1;
                m_ack_o   = rsp_ack;
                m_err_o   = rsp_err | timeout;
            end
            UNMAP: begin
                m_stall_o = 1'b1;
                m_err_o   = 1'b1;
            end
            DRAIN: begin
                m_stall_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign err_cause_o = err_cause_q;
    assign err_addr_o  = err_addr_q;

endmodule
